// File: rtl/arf_pkg.sv
// Shared types and constants for the ARF sequencing controller.
package arf_pkg;

   localparam int ARF_NUM_IN = 10;
   localparam int ARF_DW     = 32;

   typedef logic [ARF_NUM_IN-1:0][ARF_DW-1:0] arf_frame_t;
   typedef logic [1:0][ARF_DW-1:0]            arf_pair_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      CAPT = 2'd2,
      EMIT = 2'd3
   } arf_state_t;

endpackage

// File: rtl/arf_err_acc.sv
// One lane of error statistics: e = var - acc (signed, DW+1 bits), a wrapping
// signed sum of e and a saturating unsigned sum of e*e.
module arf_err_acc #(
   parameter int DW    = 32,
   parameter int SUM_W = 48,
   parameter int SQ_W  = 80
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             en,
   input  logic [DW-1:0]    var_in,
   input  logic [DW-1:0]    acc_in,
   output logic [SUM_W-1:0] err_sum,
   output logic [SQ_W-1:0]  err_sq
);

   localparam int EW = DW + 1;
   localparam int PW = 2 * EW;
   localparam int AW = ((SQ_W > PW) ? SQ_W : PW) + 1;

   logic signed [EW-1:0] e;
   logic signed [PW-1:0] e_w;
   logic [PW-1:0]        sq;
   logic [AW-1:0]        sq_next;

   assign e       = $signed({var_in[DW-1], var_in}) - $signed({acc_in[DW-1], acc_in});
   assign e_w     = PW'(e);
   assign sq      = e_w * e_w;
   // One spare bit above the wider operand so the overflow is always visible.
   assign sq_next = AW'(err_sq) + AW'(sq);

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         err_sum <= '0;
         err_sq  <= '0;
      end else if (en) begin
         err_sum <= err_sum + SUM_W'(e);
         if (sq_next > AW'({SQ_W{1'b1}}))
            err_sq <= {SQ_W{1'b1}};
         else
            err_sq <= sq_next[SQ_W-1:0];
      end
   end

endmodule

// File: rtl/arf_sched_ctrl.sv
// Sequencer for the arf_variance / arf_accurate datapath pair: launch, settle,
// capture, emit. Error statistics are built only when ARF_ERR_STATS_EN is defined.
module arf_sched_ctrl
   import arf_pkg::*;
#(
   parameter int DW    = 32,
   parameter int LAT   = 4,
   parameter int CNT_W = 32,
   parameter int SUM_W = 48,
   parameter int SQ_W  = 80
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [ARF_NUM_IN*DW-1:0]   in_frame,
   output logic [ARF_NUM_IN*DW-1:0]   dp_opnd,
   input  logic [2*DW-1:0]            dp_var,
   input  logic [2*DW-1:0]            dp_acc,
   output logic                       res_valid,
   input  logic                       res_ready,
   output logic [2*DW-1:0]            res_out,
   input  logic                       stat_clr,
   output logic [CNT_W-1:0]           sample_cnt,
   output logic [2*SUM_W-1:0]         err_sum,
   output logic [2*SQ_W-1:0]          err_sq,
   output arf_state_t                 state_dbg
);

   // Handshakes: a transfer happens on a clock edge where valid && ready are
   // both high; valid/data hold until then, and ready never depends on the
   // other side's valid or ready in the same cycle.

   arf_state_t state, state_nxt;
   logic [7:0] wait_cnt;
   logic       accept;
   logic       capture;

   assign accept    = (state == IDLE) && in_valid;
   assign capture   = (state == CAPT);
   assign state_dbg = state;

   always_comb begin
      state_nxt = state;
      in_ready  = 1'b0;
      res_valid = 1'b0;
      case (state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) state_nxt = WAIT;
         end
         WAIT: if (wait_cnt == 8'd0) state_nxt = CAPT;
         CAPT: state_nxt = EMIT;
         EMIT: begin
            res_valid = 1'b1;
            if (res_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         wait_cnt <= 8'd0;
         dp_opnd  <= '0;
         res_out  <= '0;
      end else begin
         state <= state_nxt;
         if (accept) begin
            dp_opnd  <= in_frame;
            wait_cnt <= 8'(LAT - 1);
         end else if (state == WAIT && wait_cnt != 8'd0) begin
            wait_cnt <= wait_cnt - 8'd1;
         end
         if (capture) res_out <= dp_var;
      end
   end

   // Clear takes priority over the increment of a coincident capture.
   always_ff @(posedge clk) begin
      if (rst || stat_clr)
         sample_cnt <= '0;
      else if (capture)
         sample_cnt <= sample_cnt + CNT_W'(1);
   end

`ifdef ARF_ERR_STATS_EN
   arf_err_acc #(.DW(DW), .SUM_W(SUM_W), .SQ_W(SQ_W)) u_acc27 (
      .clk     (clk),
      .rst     (rst),
      .clr     (stat_clr),
      .en      (capture),
      .var_in  (dp_var[DW-1:0]),
      .acc_in  (dp_acc[DW-1:0]),
      .err_sum (err_sum[SUM_W-1:0]),
      .err_sq  (err_sq[SQ_W-1:0])
   );

   arf_err_acc #(.DW(DW), .SUM_W(SUM_W), .SQ_W(SQ_W)) u_acc28 (
      .clk     (clk),
      .rst     (rst),
      .clr     (stat_clr),
      .en      (capture),
      .var_in  (dp_var[2*DW-1:DW]),
      .acc_in  (dp_acc[2*DW-1:DW]),
      .err_sum (err_sum[2*SUM_W-1:SUM_W]),
      .err_sq  (err_sq[2*SQ_W-1:SQ_W])
   );
`else
   logic acc_unused;
   assign acc_unused = ^dp_acc;
   assign err_sum    = '0;
   assign err_sq     = '0;
`endif

endmodule

// File: tb/tb_arf_sched_ctrl.sv
// Directed bench for arf_sched_ctrl: a default build and an SQ_W=8 build run in
// lockstep against a scoreboard of expected results and a statistics model.
module tb_arf_sched_ctrl;
   import arf_pkg::*;

   localparam int DW  = 32;
   localparam int LAT = 4;
   localparam int FW  = 10 * DW;
   localparam int PW  = 2 * DW;
`ifdef ARF_ERR_STATS_EN
   localparam bit STATS = 1'b1;
`else
   localparam bit STATS = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst, in_valid, res_ready, stat_clr;
   logic [FW-1:0] in_frame;
   logic [PW-1:0] dp_var, dp_acc;

   logic          in_ready, res_valid;
   logic [FW-1:0] dp_opnd;
   logic [PW-1:0] res_out;
   logic [31:0]   sample_cnt;
   logic [95:0]   err_sum;
   logic [159:0]  err_sq;
   arf_state_t    state_dbg;

   logic          d8_unused_in_ready, d8_unused_res_valid;
   logic [FW-1:0] d8_unused_dp_opnd;
   logic [PW-1:0] d8_unused_res_out;
   arf_state_t    d8_unused_state;
   logic [31:0]   d8_sample_cnt;
   logic [95:0]   d8_err_sum;
   logic [15:0]   d8_err_sq;

   always #5 clk = ~clk;

   arf_sched_ctrl #(.DW(DW), .LAT(LAT)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_frame(in_frame), .dp_opnd(dp_opnd), .dp_var(dp_var), .dp_acc(dp_acc),
      .res_valid(res_valid), .res_ready(res_ready), .res_out(res_out),
      .stat_clr(stat_clr), .sample_cnt(sample_cnt), .err_sum(err_sum),
      .err_sq(err_sq), .state_dbg(state_dbg)
   );

   arf_sched_ctrl #(.DW(DW), .LAT(LAT), .SQ_W(8)) dut8 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(d8_unused_in_ready),
      .in_frame(in_frame), .dp_opnd(d8_unused_dp_opnd), .dp_var(dp_var), .dp_acc(dp_acc),
      .res_valid(d8_unused_res_valid), .res_ready(res_ready), .res_out(d8_unused_res_out),
      .stat_clr(stat_clr), .sample_cnt(d8_sample_cnt), .err_sum(d8_err_sum),
      .err_sq(d8_err_sq), .state_dbg(d8_unused_state)
   );

   int n_vec = 0;
   int n_mis = 0;
   logic [PW-1:0] exp_q[$];

   logic [31:0] m_cnt;
   logic [47:0] m_sum27, m_sum28;
   logic [79:0] m_sq27, m_sq28;
   logic [7:0]  m8_sq27, m8_sq28;

   task automatic chk(input string tag, input logic [FW-1:0] obs, input logic [FW-1:0] expv);
      n_vec++;
      assert (obs === expv) else begin
         n_mis++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   // Reference error model: plain 64-bit arithmetic, no reuse of RTL widths.
   function automatic longint err_of(input logic [31:0] v, input logic [31:0] a);
      return longint'($signed(v)) - longint'($signed(a));
   endfunction

   function automatic logic [79:0] sat80(input logic [79:0] acc, input logic [63:0] p);
      logic [80:0] t;
      t = 81'(acc) + 81'(p);
      return t[80] ? 80'hFFFF_FFFF_FFFF_FFFF_FFFF : t[79:0];
   endfunction

   function automatic logic [7:0] sat8(input logic [7:0] acc, input logic [63:0] p);
      logic [64:0] t;
      t = 65'(acc) + 65'(p);
      return (t > 65'd255) ? 8'hFF : t[7:0];
   endfunction

   task automatic model_clear();
      m_cnt = '0; m_sum27 = '0; m_sum28 = '0;
      m_sq27 = '0; m_sq28 = '0; m8_sq27 = '0; m8_sq28 = '0;
   endtask

   task automatic model_frame(input logic [PW-1:0] v, input logic [PW-1:0] a);
      longint e27, e28;
      logic [63:0] p27, p28;
      e27 = err_of(v[31:0], a[31:0]);
      e28 = err_of(v[63:32], a[63:32]);
      p27 = 64'(e27 * e27);
      p28 = 64'(e28 * e28);
      m_cnt   = m_cnt + 32'd1;
      m_sum27 = m_sum27 + 48'(e27);
      m_sum28 = m_sum28 + 48'(e28);
      m_sq27  = sat80(m_sq27, p27);
      m_sq28  = sat80(m_sq28, p28);
      m8_sq27 = sat8(m8_sq27, p27);
      m8_sq28 = sat8(m8_sq28, p28);
   endtask

   task automatic check_stats(input string tag);
      chk({tag, "_cnt"},    FW'(sample_cnt),    FW'(m_cnt));
      chk({tag, "_cnt8"},   FW'(d8_sample_cnt), FW'(m_cnt));
      chk({tag, "_sum"},    FW'(err_sum),    STATS ? FW'({m_sum28, m_sum27}) : '0);
      chk({tag, "_sq"},     FW'(err_sq),     STATS ? FW'({m_sq28, m_sq27}) : '0);
      chk({tag, "_sum8"},   FW'(d8_err_sum), STATS ? FW'({m_sum28, m_sum27}) : '0);
      chk({tag, "_sq8"},    FW'(d8_err_sq),  STATS ? FW'({m8_sq28, m8_sq27}) : '0);
   endtask

   function automatic logic [FW-1:0] rand_frame();
      logic [FW-1:0] r;
      for (int i = 0; i < 10; i++) r[i*32 +: 32] = $urandom();
      return r;
   endfunction

   // Called at a falling edge with the controller expected idle.
   task automatic send_frame(input logic [FW-1:0] f, input logic [PW-1:0] v,
                             input logic [PW-1:0] a, input int hold, input bit clr_capt);
      int n;
      logic [PW-1:0] exp_r;
      dp_var = v; dp_acc = a; in_frame = f; in_valid = 1'b1; res_ready = 1'b0;
      exp_q.push_back(v);
      n = 0;
      while (!in_ready && n < 20) begin @(negedge clk); n++; end
      chk("in_ready_idle", FW'(in_ready), FW'(1));
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      chk("dp_opnd_launch", dp_opnd, f);
      chk("in_ready_busy", FW'(in_ready), FW'(0));
      n = 1;
      while (!res_valid && n < 50) begin
         if (clr_capt && n == LAT + 1) begin
            chk("state_capt", FW'(state_dbg), FW'(CAPT));
            stat_clr = 1'b1;
         end
         @(negedge clk);
         stat_clr = 1'b0;
         n++;
      end
      chk("res_valid_latency", FW'(n), FW'(LAT + 2));
      if (clr_capt) model_clear();
      else model_frame(v, a);
      check_stats("emit");
      for (int i = 0; i < hold; i++) begin
         if (i == 1) begin in_frame = ~f; in_valid = 1'b1; end
         chk("bp_res_valid", FW'(res_valid), FW'(1));
         chk("bp_res_out", FW'(res_out), FW'(exp_q[0]));
         chk("bp_in_ready", FW'(in_ready), FW'(0));
         @(negedge clk);
      end
      chk("dp_opnd_hold", dp_opnd, f);
      res_ready = 1'b1;
      #1;
      chk("in_ready_not_from_res_ready", FW'(in_ready), FW'(0));
      chk("res_valid_at_handshake", FW'(res_valid), FW'(1));
      if (exp_q.size() > 0) begin
         exp_r = exp_q.pop_front();
         chk("res_out", FW'(res_out), FW'(exp_r));
      end
      @(negedge clk);
      chk("res_valid_drop", FW'(res_valid), FW'(0));
      chk("in_ready_back", FW'(in_ready), FW'(1));
      chk("dp_opnd_no_early_accept", dp_opnd, f);
      in_valid = 1'b0; res_ready = 1'b0;
   endtask

   task automatic pulse_clr();
      stat_clr = 1'b1;
      @(negedge clk);
      stat_clr = 1'b0;
      model_clear();
      check_stats("clr");
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: observed no finish, expected finish before 500000");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [FW-1:0] f;
      rst = 1'b1; in_valid = 1'b0; res_ready = 1'b0; stat_clr = 1'b0;
      in_frame = '0; dp_var = '0; dp_acc = '0;
      model_clear();
      repeat (3) @(negedge clk);
      chk("rst_in_ready", FW'(in_ready), FW'(1));
      chk("rst_res_valid", FW'(res_valid), FW'(0));
      chk("rst_dp_opnd", dp_opnd, '0);
      chk("rst_res_out", FW'(res_out), '0);
      chk("rst_state", FW'(state_dbg), FW'(IDLE));
      check_stats("rst");
      rst = 1'b0;
      @(negedge clk);

      send_frame(rand_frame(), 64'h00000010_00000010, 64'h00000010_00000010, 0, 1'b0);
      send_frame(rand_frame(), {$urandom(), $urandom()}, {$urandom(), $urandom()}, 10, 1'b0);

      pulse_clr();
      for (int i = 0; i < 4; i++)
         send_frame(rand_frame(), {32'h5, 32'hFFFFFFFD}, {32'h5, 32'h2}, i, 1'b0);
      chk("sum27_x4", FW'(err_sum[47:0]), STATS ? FW'(48'hFFFF_FFFF_FFEC) : '0);
      chk("sq27_x4", FW'(err_sq[79:0]), STATS ? FW'(100) : '0);
      chk("cnt_x4", FW'(sample_cnt), FW'(4));

      pulse_clr();
      send_frame(rand_frame(), {32'h0, 32'h10}, 64'h0, 0, 1'b0);
      chk("sat8_first", FW'(d8_err_sq[7:0]), STATS ? FW'(255) : '0);
      send_frame(rand_frame(), {32'h0, 32'h10}, 64'h0, 0, 1'b0);
      chk("sat8_second", FW'(d8_err_sq[7:0]), STATS ? FW'(255) : '0);
      pulse_clr();

      send_frame(rand_frame(), {32'h1234, 32'h77}, {32'h1, 32'h2}, 0, 1'b0);
      send_frame(rand_frame(), {32'hCAFE0001, 32'h00ABCDEF}, {32'h1, 32'h2}, 2, 1'b1);

      send_frame(rand_frame(), {32'h9, 32'h3}, {32'h1, 32'h1}, 0, 1'b0);
      f = rand_frame();
      in_frame = f; in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      chk("abort_in_wait", FW'(state_dbg), FW'(WAIT));
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      model_clear();
      chk("abort_state", FW'(state_dbg), FW'(IDLE));
      chk("abort_in_ready", FW'(in_ready), FW'(1));
      chk("abort_res_valid", FW'(res_valid), FW'(0));
      check_stats("abort");
      send_frame(rand_frame(), {32'h100, 32'h200}, {32'h80, 32'h300}, 1, 1'b0);

      send_frame(rand_frame(), {32'h7FFFFFFF, 32'h80000000}, {32'h80000000, 32'h7FFFFFFF}, 0, 1'b0);
      for (int i = 0; i < 4; i++)
         send_frame(rand_frame(), {$urandom(), $urandom()}, {$urandom(), $urandom()},
                    int'($urandom_range(0, 3)), 1'b0);
      chk("scoreboard_empty", FW'(exp_q.size()), FW'(0));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
      $finish;
   end

endmodule
